// File: rtl/lc4_div_pkg.sv
// Shared constants for the LC4 sequential divider: FSM encoding and the
// legal quotient-bits-per-cycle check.
package lc4_div_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Bit n set means BITS_PER_CYCLE = n is supported.
  localparam logic [4:0] LegalBpcMask = 5'b10110;

  function automatic logic bpc_legal(input int unsigned bpc);
    if (bpc > 4) return 1'b0;
    return LegalBpcMask[bpc[2:0]];
  endfunction

endpackage

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and shift the resulting quotient bit in.
module lc4_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dividend_next,
  output logic [WIDTH-1:0] quotient_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    shifted = {rem, dividend[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // rem < divisor keeps shifted < 2*divisor, so the top bit of diff is a clean borrow.
    ge            = ~diff[WIDTH];
    rem_next      = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dividend_next = {dividend[WIDTH-2:0], 1'b0};
    quotient_next = {quotient[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/lc4_divider_seq.sv
// Iterative restoring divider for the LC4 execute stage: BITS_PER_CYCLE quotient
// bits per clock, valid/ready on both sides, optional signed mode and tag passthrough.
module lc4_divider_seq
  import lc4_div_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int unsigned NumSteps = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW     = $clog2(NumSteps + 1);

  if (!bpc_legal(BITS_PER_CYCLE) || (WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 4 ||
      (WIDTH % 2) != 0) begin : g_bad_params
    $error("lc4_divider_seq: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, dvd_q, quo_q, dvs_q;
  logic             neg_quo_q, neg_rem_q, dbz_q;
  logic [TAG_W-1:0] tag_q;

  logic [WIDTH-1:0] quo_out_q, rem_out_q;
  logic             dbz_out_q;
  logic [TAG_W-1:0] tag_out_q;

  logic             accept, last_step;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  logic [WIDTH-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] dvd_c [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_c [BITS_PER_CYCLE+1];

  assign o_ready   = (state_q == StIdle) | ((state_q == StDone) & i_ready);
  assign accept    = i_valid & o_ready;
  assign last_step = (state_q == StBusy) && (cnt_q == CntW'(1));

  assign o_valid       = (state_q == StDone);
  assign o_busy        = (state_q == StBusy);
  assign o_quotient    = quo_out_q;
  assign o_remainder   = rem_out_q;
  assign o_div_by_zero = dbz_out_q;
  assign o_tag         = tag_out_q;

  assign rem_c[0] = rem_q;
  assign dvd_c[0] = dvd_q;
  assign quo_c[0] = quo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    lc4_div_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem          (rem_c[g]),
      .dividend     (dvd_c[g]),
      .quotient     (quo_c[g]),
      .divisor      (dvs_q),
      .rem_next     (rem_c[g+1]),
      .dividend_next(dvd_c[g+1]),
      .quotient_next(quo_c[g+1])
    );
  end

  always_comb begin
    dvd_neg = i_signed & i_dividend[WIDTH-1];
    dvs_neg = i_signed & i_divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -i_dividend : i_dividend;
    dvs_mag = dvs_neg ? -i_divisor : i_divisor;
  end

  // MIN / -1 falls out naturally: |MIN| is MIN as unsigned, and negating it is MIN again.
  always_comb begin
    quo_fix = neg_quo_q ? -quo_c[BITS_PER_CYCLE] : quo_c[BITS_PER_CYCLE];
    rem_fix = neg_rem_q ? -rem_c[BITS_PER_CYCLE] : rem_c[BITS_PER_CYCLE];
    if (dbz_q) begin
      quo_fix = '0;
      rem_fix = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (last_step) state_d = StDone;
      StDone:  if (i_ready) state_d = accept ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      tag_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
      tag_out_q <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        cnt_q     <= CntW'(NumSteps);
        rem_q     <= '0;
        quo_q     <= '0;
        dvd_q     <= dvd_mag;
        dvs_q     <= dvs_mag;
        neg_quo_q <= dvd_neg ^ dvs_neg;
        neg_rem_q <= dvd_neg;
        dbz_q     <= (i_divisor == '0);
        tag_q     <= i_tag;
      end else if (state_q == StBusy) begin
        cnt_q <= cnt_q - CntW'(1);
        rem_q <= rem_c[BITS_PER_CYCLE];
        dvd_q <= dvd_c[BITS_PER_CYCLE];
        quo_q <= quo_c[BITS_PER_CYCLE];
      end

      // Result registers are nonzero only while DONE.
      if (last_step) begin
        quo_out_q <= quo_fix;
        rem_out_q <= rem_fix;
        dbz_out_q <= dbz_q;
        tag_out_q <= tag_q;
      end else if ((state_q == StDone) && i_ready) begin
        quo_out_q <= '0;
        rem_out_q <= '0;
        dbz_out_q <= 1'b0;
        tag_out_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lc4_divider_seq.sv
// Directed and randomized checks of lc4_divider_seq at BITS_PER_CYCLE = 1, 2 and 4.
module tb_lc4_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [3];
  logic        ir   [3];
  logic        isg  [3];
  logic [15:0] idd  [3];
  logic [15:0] ids  [3];
  logic [3:0]  itg  [3];
  logic        ordy [3];
  logic        ov   [3];
  logic        obsy [3];
  logic        odbz [3];
  logic [15:0] oq   [3];
  logic [15:0] orm  [3];
  logic [3:0]  otg  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lc4_divider_seq #(
      .WIDTH         (16),
      .BITS_PER_CYCLE(1 << g),
      .TAG_W         (4)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (iv[g]),
      .o_ready      (ordy[g]),
      .i_signed     (isg[g]),
      .i_dividend   (idd[g]),
      .i_divisor    (ids[g]),
      .i_tag        (itg[g]),
      .o_valid      (ov[g]),
      .i_ready      (ir[g]),
      .o_quotient   (oq[g]),
      .o_remainder  (orm[g]),
      .o_div_by_zero(odbz[g]),
      .o_tag        (otg[g]),
      .o_busy       (obsy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle index (accept cycle = 0) at which o_valid is first seen.
  task automatic wait_valid(input int k, output int lat);
    lat = 1;
    while (!ov[k] && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input int k, input logic sg, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tg, output logic [15:0] q, output logic [15:0] r,
                        output logic dz, output logic [3:0] to, output int lat);
    isg[k] = sg;
    idd[k] = a;
    ids[k] = b;
    itg[k] = tg;
    iv[k]  = 1'b1;
    step();
    iv[k]  = 1'b0;
    idd[k] = 16'($urandom);
    ids[k] = 16'($urandom);
    itg[k] = 4'($urandom);
    isg[k] = ~sg;
    wait_valid(k, lat);
    q  = oq[k];
    r  = orm[k];
    dz = odbz[k];
    to = otg[k];
    ir[k] = 1'b1;
    step();
    ir[k] = 1'b0;
  endtask

  task automatic directed(input string name, input logic sg, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] tg, input logic [15:0] eq,
                          input logic [15:0] er, input logic edz);
    logic [15:0] q, r;
    logic        dz;
    logic [3:0]  to;
    int          lat;
    run_op(0, sg, a, b, tg, q, r, dz, to, lat);
    check({name, ".quo"}, q, eq);
    check({name, ".rem"}, r, er);
    check({name, ".dbz"}, dz, edz);
    check({name, ".tag"}, to, tg);
    check({name, ".lat"}, lat, 17);
  endtask

  function automatic void ref_div(input logic sg, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz);
    int sa, sb;
    dz = (b == 16'h0);
    if (dz) begin
      q = 16'h0;
      r = 16'h0;
    end else if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -32768 && sb == -1) begin
        q = 16'h8000;
        r = 16'h0;
      end else begin
        q = 16'(sa / sb);
        r = 16'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  initial begin
    logic [15:0] q, r, eq, er, a, b;
    logic        dz, edz, sg;
    logic [3:0]  to, tg;
    int          lat, seen;

    for (int k = 0; k < 3; k++) begin
      iv[k] = 0; ir[k] = 0; isg[k] = 0; idd[k] = 0; ids[k] = 0; itg[k] = 0;
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset.valid", ov[0], 0);
    check("reset.busy", obsy[0], 0);
    check("reset.ready", ordy[0], 1);
    check("reset.quo", oq[0], 0);
    check("reset.rem", orm[0], 0);
    check("reset.dbz", odbz[0], 0);
    check("reset.tag", otg[0], 0);

    directed("u100d7", 1'b0, 16'd100, 16'd7, 4'd1, 16'd14, 16'd2, 1'b0);
    directed("dbz", 1'b0, 16'd1234, 16'd0, 4'd2, 16'd0, 16'd0, 1'b1);
    directed("uffffd1", 1'b0, 16'hFFFF, 16'd1, 4'd3, 16'hFFFF, 16'd0, 1'b0);
    directed("sm7d2", 1'b1, 16'hFFF9, 16'd2, 4'd4, 16'hFFFD, 16'hFFFF, 1'b0);
    directed("s7dm2", 1'b1, 16'd7, 16'hFFFE, 4'd5, 16'hFFFD, 16'h0001, 1'b0);
    directed("sminm1", 1'b1, 16'h8000, 16'hFFFF, 4'd6, 16'h8000, 16'h0000, 1'b0);
    directed("uminm1", 1'b0, 16'h8000, 16'hFFFF, 4'd7, 16'h0000, 16'h8000, 1'b0);

    // Backpressure in DONE, then back-to-back accept as the result drains.
    isg[0] = 0; idd[0] = 16'd100; ids[0] = 16'd7; itg[0] = 4'd3; iv[0] = 1;
    step();
    iv[0] = 0;
    wait_valid(0, lat);
    check("bp.lat", lat, 17);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp.valid", ov[0], 1);
      check("bp.ready", ordy[0], 0);
      check("bp.quo", oq[0], 14);
      check("bp.rem", orm[0], 2);
      check("bp.tag", otg[0], 3);
    end
    idd[0] = 16'd50; ids[0] = 16'd5; itg[0] = 4'd9; iv[0] = 1; ir[0] = 1;
    #1;
    check("b2b.ready", ordy[0], 1);
    step();
    iv[0] = 0; ir[0] = 0;
    check("b2b.busy", obsy[0], 1);
    check("b2b.valid", ov[0], 0);
    check("b2b.quo_cleared", oq[0], 0);
    check("b2b.tag_cleared", otg[0], 0);
    wait_valid(0, lat);
    check("b2b.lat", lat, 17);
    check("b2b.tag", otg[0], 9);
    check("b2b.quo", oq[0], 10);
    check("b2b.rem", orm[0], 0);
    ir[0] = 1;
    step();
    ir[0] = 0;

    // Reset on BUSY cycle 8 drops the operation.
    idd[0] = 16'd1000; ids[0] = 16'd3; itg[0] = 4'd11; iv[0] = 1;
    step();
    iv[0] = 0;
    repeat (7) step();
    check("midrst.busy_before", obsy[0], 1);
    rst = 1;
    step();
    rst = 0;
    check("midrst.busy", obsy[0], 0);
    check("midrst.valid", ov[0], 0);
    check("midrst.ready", ordy[0], 1);
    check("midrst.quo", oq[0], 0);
    check("midrst.rem", orm[0], 0);
    check("midrst.tag", otg[0], 0);
    seen = 0;
    ir[0] = 1;
    repeat (20) begin
      step();
      if (ov[0]) seen++;
    end
    ir[0] = 0;
    check("midrst.no_valid", seen, 0);
    directed("after_rst", 1'b0, 16'd50, 16'd5, 4'd12, 16'd10, 16'd0, 1'b0);

    // Reset beats a simultaneous request.
    rst = 1; iv[0] = 1; idd[0] = 16'd9; ids[0] = 16'd3;
    step();
    rst = 0; iv[0] = 0;
    step();
    check("rst_wins.busy", obsy[0], 0);
    check("rst_wins.valid", ov[0], 0);

    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 2000; i++) begin
        sg = 1'($urandom_range(0, 1));
        a  = 16'($urandom);
        case ($urandom_range(0, 7))
          0:       b = 16'h0;
          1:       b = 16'($urandom_range(1, 15));
          2:       b = 16'hFFFF;
          3:       begin a = 16'h8000; b = 16'hFFFF; end
          default: b = 16'($urandom);
        endcase
        tg = 4'($urandom);
        ref_div(sg, a, b, eq, er, edz);
        run_op(k, sg, a, b, tg, q, r, dz, to, lat);
        check($sformatf("sweep%0d.quo %h/%h s=%0d", k, a, b, sg), q, eq);
        check($sformatf("sweep%0d.rem %h/%h s=%0d", k, a, b, sg), r, er);
        check($sformatf("sweep%0d.dbz", k), dz, edz);
        check($sformatf("sweep%0d.tag", k), to, tg);
        check($sformatf("sweep%0d.lat", k), lat, (16 >> k) + 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
